// File: rtl/mem_lsu_bridge.sv
// Load/store bridge from a byte-addressed request port onto a word-only 8 KB SRAM bank bus.
// Sub-word stores use read-modify-write; misaligned, out-of-window or reserved-size requests return an error without touching the bus.
module mem_lsu_bridge #(
   parameter logic [15:0] BASE_HI = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_wen,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_mem_en,
   output logic        o_mem_wen,
   output logic [2:0]  o_mem_cs,
   output logic [12:0] o_mem_addr,
   output logic [1:0]  o_mem_size,
   output logic [31:0] o_mem_din,
   input  logic [31:0] i_mem_dout
);

   // state | meaning
   // IDLE  | ready for a request
   // RD    | word read on the bus
   // CAP   | capture read data: load result or merge into store buffer
   // WR    | word write on the bus
   // RESP  | response held until rsp_ready
   typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_addr;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_wen;
   logic [31:0] r_wbuf;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_accept;
   logic        w_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   assign w_accept = i_req_valid && (r_state == S_IDLE);

   assign w_err = (i_req_addr[31:16] != BASE_HI)
               || (i_req_size == 2'b11)
               || ((i_req_size == 2'b01) && i_req_addr[0])
               || ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));

   assign w_byte = i_mem_dout[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = i_mem_dout[{r_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_load  = i_mem_dout;
      w_merge = i_mem_dout;
      case (r_size)
         2'b00: begin
            w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wbuf[7:0];
         end
         2'b01: begin
            w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wbuf[15:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_err)                                  w_next = S_RESP;
               else if (i_req_wen && i_req_size == 2'b10)  w_next = S_WR;
               else                                        w_next = S_RD;
            end
         end
         S_RD:    w_next = S_CAP;
         S_CAP:   w_next = r_wen ? S_WR : S_RESP;
         S_WR:    w_next = S_RESP;
         S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_wen      <= 1'b0;
         r_wbuf     <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr     <= i_req_addr[15:0];
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_wen      <= i_req_wen;
            r_wbuf     <= i_req_wdata;
            r_rdata    <= '0;
            r_err      <= w_err;
         end else if (r_state == S_CAP) begin
            // r_wbuf still holds the right-justified store data until the merge
            if (r_wen) r_wbuf  <= w_merge;
            else       r_rdata <= w_load;
         end
      end
   end

   assign o_req_ready = (r_state == S_IDLE);
   assign o_rsp_valid = (r_state == S_RESP);
   assign o_rsp_rdata = r_rdata;
   assign o_rsp_err   = r_err;
   assign o_mem_en    = (r_state == S_RD) || (r_state == S_WR);
   assign o_mem_wen   = (r_state == S_WR);
   assign o_mem_cs    = r_addr[15:13];
   assign o_mem_addr  = {r_addr[12:2], 2'b00};
   assign o_mem_size  = 2'b10;
   assign o_mem_din   = (r_state == S_WR) ? r_wbuf : 32'h0;

endmodule

// File: tb/tb_mem_lsu_bridge.sv
// Directed bench for mem_lsu_bridge with a behavioural SRAM bank model (registered read data).
module tb_mem_lsu_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req_valid, o_req_ready, i_req_wen, i_req_unsigned;
   logic [1:0]  i_req_size;
   logic [31:0] i_req_addr, i_req_wdata;
   logic        o_rsp_valid, i_rsp_ready, o_rsp_err;
   logic [31:0] o_rsp_rdata;
   logic        o_mem_en, o_mem_wen;
   logic [2:0]  o_mem_cs;
   logic [12:0] o_mem_addr;
   logic [1:0]  o_mem_size;
   logic [31:0] o_mem_din, i_mem_dout;

   int checks = 0;
   int failures = 0;

   mem_lsu_bridge #(.BASE_HI(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_wen(i_req_wen), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
      .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
      .o_mem_en(o_mem_en), .o_mem_wen(o_mem_wen), .o_mem_cs(o_mem_cs),
      .o_mem_addr(o_mem_addr), .o_mem_size(o_mem_size), .o_mem_din(o_mem_din),
      .i_mem_dout(i_mem_dout)
   );

   always #5 clk = ~clk;

   // SRAM bank model: 8 banks x 2048 words, indexed by {cs, word address}
   logic [31:0] mem [0:16383];
   int          tot_rd = 0;
   int          tot_wr = 0;
   logic [2:0]  last_cs;
   logic [12:0] last_addr;
   logic [31:0] last_din;
   logic [1:0]  last_size;

   always @(posedge clk) begin
      if (o_mem_en) begin
         last_cs   <= o_mem_cs;
         last_addr <= o_mem_addr;
         last_size <= o_mem_size;
         if (o_mem_wen) begin
            mem[{o_mem_cs, o_mem_addr[12:2]}] <= o_mem_din;
            last_din <= o_mem_din;
            tot_wr++;
         end else begin
            i_mem_dout <= mem[{o_mem_cs, o_mem_addr[12:2]}];
            tot_rd++;
         end
      end
   end

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one request, checks latency, response and bus-access counts, then completes the response.
   task automatic txn(input logic wen, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
      int lat;
      int rd0, wr0;
      rd0 = tot_rd;
      wr0 = tot_wr;
      chk(32'(o_req_ready), 32'd1, {tag, " ready"});
      i_req_valid = 1'b1; i_req_wen = wen; i_req_size = size;
      i_req_unsigned = uns; i_req_addr = addr; i_req_wdata = wdata;
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      i_req_wen = 1'($urandom); i_req_size = 2'($urandom); i_req_unsigned = 1'($urandom);
      i_req_addr = $urandom; i_req_wdata = $urandom;
      lat = 1;
      while (!o_rsp_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      chk(32'(lat), 32'(exp_lat), {tag, " latency"});
      chk(o_rsp_rdata, exp_rd, {tag, " rdata"});
      chk(32'(o_rsp_err), 32'(exp_err), {tag, " err"});
      chk(32'(tot_rd - rd0), (exp_lat >= 3) ? 32'd1 : 32'd0, {tag, " reads"});
      chk(32'(tot_wr - wr0), (exp_lat == 2 || exp_lat == 4) ? 32'd1 : 32'd0, {tag, " writes"});
      i_rsp_ready = 1'b1;
      @(posedge clk); #1;
      i_rsp_ready = 1'b0;
      chk(32'(o_rsp_valid), 32'd0, {tag, " rsp dropped"});
   endtask

   initial begin
      int n, rd0, wr0, wait_c;
      int acc [4];
      rst_n = 1'b0;
      i_req_valid = 0; i_req_wen = 0; i_req_size = 0; i_req_unsigned = 0;
      i_req_addr = 0; i_req_wdata = 0; i_rsp_ready = 0;
      #2;
      chk(32'(o_rsp_valid), 32'd0, "reset rsp_valid");
      chk(o_rsp_rdata, 32'd0, "reset rsp_rdata");
      chk(32'(o_rsp_err), 32'd0, "reset rsp_err");
      chk({30'd0, o_mem_en, o_mem_wen}, 32'd0, "reset mem_en/wen");
      chk({16'd0, o_mem_cs, o_mem_addr}, 32'd0, "reset mem_cs/addr");
      chk(o_mem_din, 32'd0, "reset mem_din");
      #21 rst_n = 1'b1;
      chk(32'(o_req_ready), 32'd1, "reset req_ready");
      @(posedge clk); #1;

      // preload through word stores
      txn(1, 2'b10, 0, 32'h0000_2008, 32'h8899AABB, 2, 32'h0, 0, "st bank1");
      chk(last_din, 32'h8899AABB, "st bank1 din");
      chk(32'(last_size), 32'd2, "st bank1 size");
      txn(1, 2'b10, 0, 32'h0000_0000, 32'h80FF1234, 2, 32'h0, 0, "st w0");
      txn(1, 2'b10, 0, 32'h0000_0004, 32'h11223344, 2, 32'h0, 0, "st w1");

      txn(0, 2'b10, 0, 32'h0000_2008, 32'h0, 3, 32'h8899AABB, 0, "ld word");
      chk(32'(last_cs), 32'd1, "ld word cs");
      chk(32'(last_addr), 32'h0008, "ld word addr");
      txn(0, 2'b00, 0, 32'h0000_0003, 32'h0, 3, 32'hFFFFFF80, 0, "ld byte s");
      txn(0, 2'b00, 1, 32'h0000_0003, 32'h0, 3, 32'h00000080, 0, "ld byte u");
      txn(0, 2'b01, 0, 32'h0000_0002, 32'h0, 3, 32'hFFFF80FF, 0, "ld half s");
      txn(0, 2'b01, 1, 32'h0000_0000, 32'h0, 3, 32'h00001234, 0, "ld half u");
      txn(0, 2'b00, 0, 32'h0000_0001, 32'h0, 3, 32'h00000012, 0, "ld byte1");

      txn(1, 2'b00, 0, 32'h0000_0005, 32'hFFFFFF5A, 4, 32'h0, 0, "st byte");
      chk(last_din, 32'h11225A44, "st byte din");
      txn(0, 2'b10, 0, 32'h0000_0004, 32'h0, 3, 32'h11225A44, 0, "rb byte");
      txn(1, 2'b01, 0, 32'h0000_0006, 32'h1234BEEF, 4, 32'h0, 0, "st half");
      txn(0, 2'b10, 0, 32'h0000_0004, 32'h0, 3, 32'hBEEF5A44, 0, "rb half");

      txn(0, 2'b10, 0, 32'h0001_0000, 32'h0, 1, 32'h0, 1, "err window");
      txn(0, 2'b01, 0, 32'h0000_0001, 32'h0, 1, 32'h0, 1, "err half");
      txn(1, 2'b10, 0, 32'h0000_0002, 32'hFFFF, 1, 32'h0, 1, "err word");
      txn(0, 2'b11, 0, 32'h0000_0000, 32'h0, 1, 32'h0, 1, "err size");

      // backpressure on a load response
      i_req_valid = 1; i_req_wen = 0; i_req_size = 2'b10; i_req_addr = 32'h0000_2008;
      @(posedge clk); #1;
      i_req_valid = 0;
      wait_c = 0;
      while (!o_rsp_valid && wait_c < 8) begin
         @(posedge clk); #1;
         wait_c++;
      end
      chk(32'(o_rsp_valid), 32'd1, "bp rsp arrives");
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk({o_rsp_valid, o_req_ready, o_mem_en, 29'd0}, {3'b100, 29'd0}, "bp hold flags");
         chk(o_rsp_rdata, 32'h8899AABB, "bp hold rdata");
      end
      i_rsp_ready = 1;
      @(posedge clk); #1;
      i_rsp_ready = 0;

      // back-to-back word stores with zero-wait response
      i_rsp_ready = 1;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         if (o_req_ready && n < 4) begin
            i_req_valid = 1; i_req_wen = 1; i_req_size = 2'b10; i_req_unsigned = 0;
            i_req_addr = 32'h20 + 32'(4 * n); i_req_wdata = 32'hA0A0_0000 + 32'(n);
            acc[n] = c;
            n++;
         end else if (o_req_ready) begin
            i_req_valid = 0;
         end
         @(posedge clk); #1;
      end
      i_req_valid = 0;
      i_rsp_ready = 0;
      chk(32'(n), 32'd4, "b2b accepted");
      chk(32'(acc[1] - acc[0]), 32'd3, "b2b spacing 1");
      chk(32'(acc[3] - acc[2]), 32'd3, "b2b spacing 3");
      txn(0, 2'b10, 0, 32'h0000_0020, 32'h0, 3, 32'hA0A00000, 0, "rb b2b0");
      txn(0, 2'b10, 0, 32'h0000_002C, 32'h0, 3, 32'hA0A00003, 0, "rb b2b3");

      // reset while a word store is on the bus
      txn(1, 2'b10, 0, 32'h0000_0010, 32'hCAFEF00D, 2, 32'h0, 0, "st w4");
      rd0 = tot_rd;
      wr0 = tot_wr;
      i_req_valid = 1; i_req_wen = 1; i_req_size = 2'b10; i_req_addr = 32'h10; i_req_wdata = 32'h12345678;
      @(posedge clk); #1;
      i_req_valid = 0;
      chk({o_mem_en, o_mem_wen, 30'd0}, {2'b11, 30'd0}, "rst in WR");
      chk(o_mem_din, 32'h12345678, "rst WR din");
      #2 rst_n = 1'b0;
      #1;
      chk({o_mem_en, o_mem_wen, o_rsp_valid, 29'd0}, 32'd0, "rst async flags");
      chk(o_mem_din, 32'd0, "rst async din");
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk(32'(o_req_ready), 32'd1, "rst release ready");
      repeat (3) @(posedge clk);
      #1;
      chk(32'(tot_wr - wr0), 32'd0, "rst no write");
      chk(32'(tot_rd - rd0), 32'd0, "rst no read");
      txn(0, 2'b10, 0, 32'h0000_0010, 32'h0, 3, 32'hCAFEF00D, 0, "rb after rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
